// File: rtl/array_pool_arbiter.sv
// Round-robin arbiter over a shared array-handle pool: LIFO free stack backed by a bump allocator.
// Define ARRAY_POOL_DOUBLE_FREE_CHECK_EN to track per-handle in-use bits and reject double frees.
module array_pool_arbiter #(
    parameter int MemoryElementWidth = 12,
    parameter int NArrays            = 8,
    parameter int NReq               = 3
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic [NReq-1:0]                    req_valid_i,
    input  logic [NReq-1:0]                    req_free_i,
    input  logic [NReq*MemoryElementWidth-1:0] req_handle_i,
    output logic [NReq-1:0]                    req_ready_o,
    output logic [NReq-1:0]                    rsp_valid_o,
    output logic [MemoryElementWidth-1:0]      rsp_handle_o,
    output logic                               rsp_error_o,
    output logic                               size_clear_o,
    output logic [MemoryElementWidth-1:0]      size_clear_index_o,
    output logic [MemoryElementWidth-1:0]      in_use_o,
    output logic [MemoryElementWidth-1:0]      peak_o,
    output logic                               busy_o
);
    localparam int W  = MemoryElementWidth;
    localparam int PW = (NReq > 1) ? $clog2(NReq) : 1;
    localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] N_LIMIT = W'(NArrays);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [W-1:0]    allocs_q, freed_top_q, in_use_q, peak_q;
    logic [NReq-1:0] rsp_valid_q;
    logic [W-1:0]    rsp_handle_q, size_clear_index_q;
    logic            rsp_error_q, size_clear_q;
    logic [W-1:0]    freed_stack [NArrays];
`ifdef ARRAY_POOL_DOUBLE_FREE_CHECK_EN
    logic [NArrays-1:0] used_q;
`endif

    logic [PW-1:0] grant_idx;
    logic          found, grant_any, sel_free, bad_free, push;
    logic [W-1:0]  sel_handle, pop_handle, in_use_inc;

    // Scan starts one past the last winner so every requester eventually wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = ptr_q;
        for (int off = 1; off <= NReq; off++) begin
            int cand;
            cand = (int'(ptr_q) + off) % NReq;
            if (!found && req_valid_i[cand]) begin
                found     = 1'b1;
                grant_idx = PW'(cand);
            end
        end
    end

    // Reset is folded in so req_ready also reads 0 while reset is held.
    assign grant_any   = found && (state_q == IDLE) && !flush_i && reset_i;
    assign req_ready_o = grant_any ? (NReq'(1) << grant_idx) : '0;
    assign sel_free    = req_free_i[grant_idx];
    assign sel_handle  = req_handle_i[grant_idx*W +: W];
    assign pop_handle  = freed_stack[AW'(freed_top_q - ONE)];
    assign in_use_inc  = in_use_q + ONE;

`ifdef ARRAY_POOL_DOUBLE_FREE_CHECK_EN
    assign bad_free = (sel_handle >= N_LIMIT) || (in_use_q == '0) || !used_q[AW'(sel_handle)];
`else
    assign bad_free = (sel_handle >= N_LIMIT) || (in_use_q == '0);
`endif
    assign push = grant_any && sel_free && !bad_free;

    // freedTop + in_use never exceeds NArrays, so a legal push always has a free slot.
    always_ff @(posedge clock_i) begin
        if (push) freed_stack[AW'(freed_top_q)] <= sel_handle;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q            <= IDLE;
            ptr_q              <= PW'(NReq - 1);
            allocs_q           <= '0;
            freed_top_q        <= '0;
            in_use_q           <= '0;
            peak_q             <= '0;
            rsp_valid_q        <= '0;
            rsp_handle_q       <= '0;
            rsp_error_q        <= 1'b0;
            size_clear_q       <= 1'b0;
            size_clear_index_q <= '0;
`ifdef ARRAY_POOL_DOUBLE_FREE_CHECK_EN
            used_q             <= '0;
`endif
        end else begin
            rsp_valid_q        <= '0;
            rsp_handle_q       <= '0;
            rsp_error_q        <= 1'b0;
            size_clear_q       <= 1'b0;
            size_clear_index_q <= '0;
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        state_q     <= FLUSH;
                        allocs_q    <= '0;
                        freed_top_q <= '0;
                        in_use_q    <= '0;
`ifdef ARRAY_POOL_DOUBLE_FREE_CHECK_EN
                        used_q      <= '0;
`endif
                    end else if (grant_any) begin
                        ptr_q       <= grant_idx;
                        rsp_valid_q <= req_ready_o;
                        if (sel_free) begin
                            rsp_handle_q <= sel_handle;
                            if (bad_free) begin
                                rsp_error_q <= 1'b1;
                            end else begin
                                freed_top_q        <= freed_top_q + ONE;
                                in_use_q           <= in_use_q - ONE;
                                size_clear_q       <= 1'b1;
                                size_clear_index_q <= sel_handle;
`ifdef ARRAY_POOL_DOUBLE_FREE_CHECK_EN
                                used_q[AW'(sel_handle)] <= 1'b0;
`endif
                            end
                        end else if (freed_top_q != '0 || allocs_q < N_LIMIT) begin
                            logic [W-1:0] h;
                            if (freed_top_q != '0) begin
                                h = pop_handle;
                                freed_top_q <= freed_top_q - ONE;
                            end else begin
                                h = allocs_q;
                                allocs_q <= allocs_q + ONE;
                            end
                            rsp_handle_q       <= h;
                            size_clear_q       <= 1'b1;
                            size_clear_index_q <= h;
                            in_use_q           <= in_use_inc;
                            if (in_use_inc > peak_q) peak_q <= in_use_inc;
`ifdef ARRAY_POOL_DOUBLE_FREE_CHECK_EN
                            used_q[AW'(h)] <= 1'b1;
`endif
                        end else begin
                            rsp_error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_handle_o       = rsp_handle_q;
    assign rsp_error_o        = rsp_error_q;
    assign size_clear_o       = size_clear_q;
    assign size_clear_index_o = size_clear_index_q;
    assign in_use_o           = in_use_q;
    assign peak_o             = peak_q;
    assign busy_o             = (state_q == FLUSH);
endmodule
